// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus bundle: mode/redirect, ROM, external memory, decode handoff
interface instr_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int ROM_AW  = 8,
    parameter int INSTR_W = 32
);
    logic               boot_mode;
    logic               instr_mem_over;
    logic               jmp_valid;
    logic [ADDR_W-1:0]  jmp_addr;
    logic [ROM_AW-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        input  boot_mode, instr_mem_over, jmp_valid, jmp_addr,
        output rom_addr,
        input  rom_data,
        output mem_req, mem_addr,
        input  mem_ack, mem_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        output boot_mode, instr_mem_over, jmp_valid, jmp_addr,
        input  rom_addr,
        output rom_data,
        input  mem_req, mem_addr,
        output mem_ack, mem_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch from boot ROM or external memory into a 2-entry prefetch FIFO
module instr_fetch #(
    parameter int ADDR_W  = 16,
    parameter int ROM_AW  = 8,
    parameter int INSTR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, ROM_WAIT, MEM_WAIT, MEM_DISCARD} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [1:0]         count;
    logic [1:0]         count_next;
    logic [INSTR_W-1:0] tail_data;
    logic [ADDR_W-1:0]  tail_pc;

    logic               pop;
    logic               push;
    logic [INSTR_W-1:0] push_data;
    logic               inflight;
    logic               space_ok;
    logic               can_issue;
    logic               src_rom;

    always_comb begin
        pop       = bus.instr_valid & bus.instr_ready;
        inflight  = (state == ROM_WAIT) || (state == MEM_WAIT);
        // A ROM_WAIT response lands this cycle, so it is counted against the space just like a queued entry.
        space_ok  = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
        can_issue = space_ok & ~bus.jmp_valid & ((state == IDLE) || (state == ROM_WAIT));
        src_rom   = bus.boot_mode & ~bus.instr_mem_over;
        push      = 1'b0;
        push_data = bus.rom_data;
        if (!bus.jmp_valid) begin
            if (state == ROM_WAIT) begin
                push = 1'b1;
            end else if ((state == MEM_WAIT) && bus.mem_ack) begin
                push      = 1'b1;
                push_data = bus.mem_data;
            end
        end
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= '0;
            fetch_pc     <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.rom_addr <= '0;
        end else begin
            if (bus.jmp_valid) begin
                pc <= bus.jmp_addr;
            end else if (can_issue) begin
                pc <= pc + ADDR_W'(1);
            end
            case (state)
                IDLE, ROM_WAIT: begin
                    if (can_issue) begin
                        fetch_pc <= pc;
                        if (src_rom) begin
                            bus.rom_addr <= pc[ROM_AW-1:0];
                            state        <= ROM_WAIT;
                        end else begin
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= pc;
                            state        <= MEM_WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end else if (bus.jmp_valid) begin
                        state <= MEM_DISCARD;
                    end
                end
                MEM_DISCARD: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Head entry lives directly in the output registers; tail is the second slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count           <= 2'd0;
            bus.instr_valid <= 1'b0;
            bus.instr_data  <= '0;
            bus.instr_pc    <= '0;
            tail_data       <= '0;
            tail_pc         <= '0;
        end else if (bus.jmp_valid) begin
            count           <= 2'd0;
            bus.instr_valid <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        bus.instr_data <= push_data;
                        bus.instr_pc   <= fetch_pc;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        bus.instr_data <= push_data;
                        bus.instr_pc   <= fetch_pc;
                    end else if (push) begin
                        tail_data <= push_data;
                        tail_pc   <= fetch_pc;
                    end
                end
                default: begin
                    if (pop) begin
                        bus.instr_data <= tail_data;
                        bus.instr_pc   <= tail_pc;
                        if (push) begin
                            tail_data <= push_data;
                            tail_pc   <= fetch_pc;
                        end
                    end
                end
            endcase
            count           <= count_next;
            bus.instr_valid <= (count_next != 2'd0);
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch
module tb_instr_fetch;
    logic clk;
    logic rst;

    instr_fetch_if #(.ADDR_W(16), .ROM_AW(8), .INSTR_W(32)) bus ();

    instr_fetch #(.ADDR_W(16), .ROM_AW(8), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] A = 32'hA000_0000;

    // Boot ROM model: word k holds A + k, combinational from the registered address.
    assign bus.rom_data = A + {24'h0, bus.rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, boot, over, jmp;
        logic [15:0] jaddr;
        logic        ack;
        logic [31:0] mdata;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [31:0] e_data;
        logic        e_req;
        logic [15:0] e_maddr;
        logic        c_rom;
        logic [7:0]  e_rom;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic b, input logic o, input logic j,
                       input logic [15:0] ja, input logic ak, input logic [31:0] md,
                       input logic rd, input logic ev, input logic [15:0] ep,
                       input logic [31:0] ed, input logic eq, input logic [15:0] ea,
                       input logic cr, input logic [7:0] er);
        vec_t v;
        v.rst = r; v.boot = b; v.over = o; v.jmp = j; v.jaddr = ja; v.ack = ak;
        v.mdata = md; v.ready = rd; v.e_valid = ev; v.e_pc = ep; v.e_data = ed;
        v.e_req = eq; v.e_maddr = ea; v.c_rom = cr; v.e_rom = er;
        vecs.push_back(v);
    endtask

    task automatic check(input vec_t v, input string name);
        logic ok;
        ok = (bus.instr_valid === v.e_valid) && (bus.mem_req === v.e_req);
        if (v.e_valid) ok = ok && (bus.instr_pc === v.e_pc) && (bus.instr_data === v.e_data);
        if (v.e_req)   ok = ok && (bus.mem_addr === v.e_maddr);
        if (v.c_rom)   ok = ok && (bus.rom_addr === v.e_rom);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b pc=%h data=%h req=%0b maddr=%h rom=%h, want valid=%0b pc=%h data=%h req=%0b maddr=%h rom=%h(chk %0b)",
                     name, bus.instr_valid, bus.instr_pc, bus.instr_data, bus.mem_req,
                     bus.mem_addr, bus.rom_addr, v.e_valid, v.e_pc, v.e_data, v.e_req,
                     v.e_maddr, v.e_rom, v.c_rom);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst                = v.rst;
        bus.boot_mode      = v.boot;
        bus.instr_mem_over = v.over;
        bus.jmp_valid      = v.jmp;
        bus.jmp_addr       = v.jaddr;
        bus.mem_ack        = v.ack;
        bus.mem_data       = v.mdata;
        bus.instr_ready    = v.ready;
        @(posedge clk);
        #1;
        check(v, name);
    endtask

    initial begin
        vec_t fv;
        rst = 1'b1;
        bus.boot_mode = 1'b0; bus.instr_mem_over = 1'b0; bus.jmp_valid = 1'b0;
        bus.jmp_addr = '0; bus.mem_ack = 1'b0; bus.mem_data = '0; bus.instr_ready = 1'b0;

        // ROM streaming, one instruction per cycle after the first
        add(1,1,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   0,16'h0, 1,8'h00);
        add(0,1,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   0,16'h0, 1,8'h00);
        add(0,1,0,0,16'h0,0,32'h0,1, 1,16'h0,A+0,     0,16'h0, 1,8'h01);
        add(0,1,0,0,16'h0,0,32'h0,1, 1,16'h1,A+1,     0,16'h0, 1,8'h02);
        add(0,1,0,0,16'h0,0,32'h0,1, 1,16'h2,A+2,     0,16'h0, 1,8'h03);
        add(0,1,0,0,16'h0,0,32'h0,1, 1,16'h3,A+3,     0,16'h0, 1,8'h04);
        // External with backpressure: two entries, then stall; drain resumes at pc 2
        add(1,0,0,0,16'h0,0,32'h0,0, 0,16'h0,32'h0,   0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'hD000_0000,0, 1,16'h0,32'hD000_0000, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h0,32'hD000_0000, 1,16'h1, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h0,32'hD000_0000, 1,16'h1, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h0,32'hD000_0000, 1,16'h1, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'hD000_0001,0, 1,16'h0,32'hD000_0000, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h0,32'hD000_0000, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h0,32'hD000_0000, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 1,16'h1,32'hD000_0001, 1,16'h2, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h2, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'hD000_0002,1, 1,16'h2,32'hD000_0002, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h2,32'hD000_0002, 1,16'h3, 0,8'h00);
        // Jump while waiting on external memory: stale data discarded
        add(1,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,0,0,1,16'h0100,0,32'h0,1, 0,16'h0,32'h0, 1,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'hDEAD_BEEF,1, 0,16'h0,32'h0, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h0100, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'hB000_0100,1, 1,16'h0100,32'hB000_0100, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h0101, 0,8'h00);
        // Jump coincident with ack and pop
        add(1,0,0,0,16'h0,0,32'h0,0, 0,16'h0,32'h0,   0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'h0000_0011,0, 1,16'h0,32'h0000_0011, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,0, 1,16'h0,32'h0000_0011, 1,16'h1, 0,8'h00);
        add(0,0,0,1,16'h0200,1,32'h0000_0022,1, 0,16'h0,32'h0, 0,16'h0, 0,8'h00);
        add(0,0,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h0200, 0,8'h00);
        add(0,0,0,0,16'h0,1,32'h0000_0033,1, 1,16'h0200,32'h0000_0033, 0,16'h0, 0,8'h00);
        // Source switch across the pc wrap
        add(1,1,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   0,16'h0, 1,8'h00);
        add(0,1,0,1,16'hFFFF,0,32'h0,1, 0,16'h0,32'h0, 0,16'h0, 1,8'h00);
        add(0,1,0,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   0,16'h0, 1,8'hFF);
        add(0,1,1,0,16'h0,0,32'h0,1, 1,16'hFFFF,A+32'hFF, 1,16'h0, 1,8'hFF);
        add(0,1,1,0,16'h0,0,32'h0,1, 0,16'h0,32'h0,   1,16'h0, 0,8'h00);
        add(0,1,1,0,16'h0,1,32'hC000_0000,1, 1,16'h0,32'hC000_0000, 0,16'h0, 0,8'h00);

        #3;
        n_vec++;
        if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0 ||
            bus.rom_addr !== 8'h0 || bus.instr_data !== 32'h0 || bus.instr_pc !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%0b req=%0b maddr=%h rom=%h data=%h pc=%h, want all zero",
                     bus.instr_valid, bus.mem_req, bus.mem_addr, bus.rom_addr, bus.instr_data, bus.instr_pc);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset in MEM_WAIT with an entry queued, then a late ack after release
        fv = '{rst:1, boot:0, over:0, jmp:0, jaddr:16'h0, ack:0, mdata:32'h0, ready:0,
               e_valid:0, e_pc:16'h0, e_data:32'h0, e_req:0, e_maddr:16'h0, c_rom:0, e_rom:8'h0};
        apply(fv, "ar_reset");
        fv.rst = 0; fv.e_req = 1;
        apply(fv, "ar_issue0");
        fv.ack = 1; fv.mdata = 32'h0000_0055; fv.e_req = 0; fv.e_valid = 1; fv.e_data = 32'h0000_0055;
        apply(fv, "ar_ack0");
        fv.ack = 0; fv.e_req = 1; fv.e_maddr = 16'h1;
        apply(fv, "ar_issue1");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got req=%0b valid=%0b, want req=0 valid=0",
                     bus.mem_req, bus.instr_valid);
        end
        fv = '{rst:0, boot:0, over:0, jmp:0, jaddr:16'h0, ack:1, mdata:32'h0000_0066, ready:0,
               e_valid:0, e_pc:16'h0, e_data:32'h0, e_req:1, e_maddr:16'h0, c_rom:0, e_rom:8'h0};
        apply(fv, "late_ack");
        fv.ack = 0;
        apply(fv, "late_ack_after1");
        apply(fv, "late_ack_after2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the special-register block. It consumes that block's boot_mode and instr_mem_over outputs to choose the instruction source: on-chip boot ROM or external instruction memory. It keeps a 2-entry prefetch FIFO feeding decode through a valid/ready handshake, and supports PC redirect (jump) with flush.

Parameters:
ADDR_W, 16, fetch PC / external memory word-address width
ROM_AW, 8, boot ROM word-address width (rom_addr = pc[ROM_AW-1:0])
INSTR_W, 32, instruction width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
boot_mode  input  1  1 = boot phase (from special-register block)
instr_mem_over  input  1  1 = force external memory even in boot phase
jmp_valid  input  1  redirect request, single-cycle pulse
jmp_addr  input  ADDR_W  redirect target
rom_addr  output  ROM_AW  boot ROM address, registered
rom_data  input  INSTR_W  boot ROM data, valid exactly 1 cycle after rom_addr is issued
mem_req  output  1  external fetch request
mem_addr  output  ADDR_W  external fetch address
mem_ack  input  1  external data valid, completes the request
mem_data  input  INSTR_W  external fetch data
instr_valid  output  1  FIFO head valid
instr_data  output  INSTR_W  FIFO head instruction
instr_pc  output  ADDR_W  address of FIFO head
instr_ready  input  1  decode accepts head

Behaviour:
- Reset (async): pc=0, FIFO empty, instr_valid=0, mem_req=0, mem_addr=0, rom_addr=0, instr_data=0, instr_pc=0, state IDLE, no in-flight fetch.
- Source is selected per issue and latched with the fetch: ROM if boot_mode=1 and instr_mem_over=0, otherwise external. Changes take effect at the next issue only.
- Space rule: an issue is allowed when count + inflight - pop < 2. pop = instr_valid & instr_ready. At most one fetch is in flight.
- FSM:
  - IDLE: if the space rule allows and jmp_valid=0, issue at pc. For ROM, drive rom_addr and go to ROM_WAIT. For external, assert mem_req with mem_addr=pc and go to MEM_WAIT. Then pc <= pc+1, wrapping 2^ADDR_W-1 -> 0.
  - ROM_WAIT: push rom_data with its pc, then behave as IDLE in the same cycle. This allows back-to-back issue, so throughput is 1 instr/cycle with instr_ready=1.
  - MEM_WAIT: hold mem_req and mem_addr stable until mem_ack. On ack, deassert mem_req next cycle, push mem_data, and return to IDLE. No new request is issued in the ack cycle.
  - MEM_DISCARD: keep mem_req until mem_ack, drop the data, then return to IDLE.
- FIFO: 2 entries, registered outputs. instr_data and instr_pc are stable while instr_valid=1 and instr_ready=0. Push and pop in the same cycle are allowed, including when full (pop frees the slot). No push when full can occur, by the space rule.
- Jump (jmp_valid=1):
  - pc <= jmp_addr and the FIFO is cleared.
  - A pop in the same cycle still counts as consumed, and instr_valid=0 next cycle.
  - An in-flight ROM response is dropped.
  - MEM_WAIT without ack goes to MEM_DISCARD. MEM_WAIT with mem_ack in the same cycle drops the data and goes to IDLE.
  - No issue occurs in the jump cycle; the first fetch of the target is issued the next cycle.
  - A second jump during MEM_DISCARD only updates pc.
- Latency: ROM issue on edge N, push on edge N+1, instr_valid high after edge N+1. First instr_valid after reset follows the 2nd rising edge after rst deasserts.
- Reset mid-operation: immediate return to the reset state. mem_req drops asynchronously, and any outstanding external ack is ignored.

Test Plan:
- ROM streaming: rst release, boot_mode=1, instr_mem_over=0, ROM word k = 0xA000_0000+k, instr_ready=1 -> instr_pc 0,1,2,3 on consecutive cycles with matching data, no bubbles after the first.
- External with backpressure: boot_mode=0, mem_ack 3 cycles after each req, instr_ready=0 -> exactly 2 entries fetched then mem_req stays 0. Raising instr_ready drains pc 0,1 in order, then fetch resumes at pc 2.
- Jump during external fetch: jmp_valid with jmp_addr=0x0100 while in MEM_WAIT -> mem_req held until ack, that data never appears. Next mem_addr=0x0100 and next instr_pc=0x0100.
- Jump coincident with ack and pop: jmp_valid, mem_ack and pop in the same cycle -> popped instr delivered once, acked data dropped, instr_valid=0 next cycle, target fetched.
- Source switch and wrap: jump to 0xFFFF on the ROM source, then set instr_mem_over=1 -> pc 0xFFFF comes from ROM (addr 0xFF), pc 0x0000 comes from external with mem_addr=0.
- Async reset with mem_req high: assert rst mid-MEM_WAIT -> mem_req=0 and instr_valid=0 without a clock edge. A late mem_ack after release creates no FIFO entry.
